sum_accumulator: RTL and testbench

Downstream stage for the 8-bit `sum` adder's result stream. It accepts one adder result per valid/ready handshake and accumulates `N` results into a wider total. It then presents the total, the sample count and an overflow flag on an output valid/ready handshake. The block turns a per-cycle stream of pairwise sums into framed totals for the next stage.

---
 rtl/sum_accumulator_if.sv | 27 ++
 rtl/sum_accumulator.sv | 98 +++++++++
 tb/tb_sum_accumulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Stream interface for sum_accumulator: sample input handshake plus framed result output.
// The master side feeds samples and consumes results; the slave side is the accumulator.
interface sum_accumulator_if #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    modport master (
        output in_valid, in_data, in_flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates N unsigned samples (or fewer on flush) into an AW-bit framed total.
// Define SUM_ACC_SAT_EN to saturate the total on overflow instead of wrapping.
module sum_accumulator #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input logic              clk,
    input logic              rst_n,
    sum_accumulator_if.slave bus
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf_r;

    logic          accept;
    logic [AW:0]   sum_wide;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] acc_upd;
    logic [CW-1:0] cnt_upd;
    logic          ovf_upd;
    logic          close;

    // Ready depends on state alone so the consumer's ready never reaches the producer.
    assign bus.in_ready = (state == ACC);
    assign accept       = bus.in_valid & (state == ACC);

    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch can be inferred.
        acc_upd  = acc;
        cnt_upd  = cnt;
        ovf_upd  = ovf_r;
        sum_wide = {1'b0, acc} + {{(AW + 1 - DW){1'b0}}, bus.in_data};
`ifdef SUM_ACC_SAT_EN
        // Once clamped, any further sample carries out again, so the total stays pinned.
        acc_next = sum_wide[AW] ? {AW{1'b1}} : sum_wide[AW-1:0];
`else
        acc_next = sum_wide[AW-1:0];
`endif
        if (accept) begin
            acc_upd = acc_next;
            cnt_upd = cnt + CW'(1);
            ovf_upd = ovf_r | sum_wide[AW];
        end
        // A flush closes the frame only when it would carry at least one sample.
        close = (state == ACC) &&
                ((accept && (cnt_upd == CW'(N))) || (bus.in_flush && (cnt_upd != '0)));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            ovf_r         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (close) begin
                        bus.out_sum   <= acc_upd;
                        bus.out_count <= cnt_upd;
                        bus.out_ovf   <= ovf_upd;
                        bus.out_valid <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                        ovf_r         <= 1'b0;
                        state         <= HOLD;
                    end else begin
                        acc   <= acc_upd;
                        cnt   <= cnt_upd;
                        ovf_r <= ovf_upd;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives one stimulus stream into two accumulators (AW=16 and AW=9, N=4) and
// checks both against a frame-level model built from running totals.
module tb_sum_accumulator;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_flush;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_low_a = 0;

    // Model state per DUT: index 0 is AW=16, index 1 is AW=9.
    int aw      [2] = '{16, 9};
    bit m_hold  [2];
    int m_total [2];
    int m_cnt   [2];
    int m_sum   [2];
    int m_count [2];
    bit m_ovf   [2];

    sum_accumulator_if #(.DW(DW), .AW(16), .CW(CW)) bus_a ();
    sum_accumulator_if #(.DW(DW), .AW(9),  .CW(CW)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.in_flush  = in_flush;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.in_flush  = in_flush;
    assign bus_b.out_ready = out_ready;

    sum_accumulator #(.DW(DW), .AW(16), .N(N)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    sum_accumulator #(.DW(DW), .AW(9), .N(N)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_sum(input int total, input int width);
        int max_val = (1 << width) - 1;
        if (total <= max_val) return total;
`ifdef SUM_ACC_SAT_EN
        return max_val;
`else
        return total % (1 << width);
`endif
    endfunction

    function automatic logic [31:0] obs_of(input int k, input int sel);
        logic [31:0] v;
        if (k == 0)
            case (sel)
                0: v = 32'(bus_a.in_ready);
                1: v = 32'(bus_a.out_valid);
                2: v = 32'(bus_a.out_sum);
                3: v = 32'(bus_a.out_count);
                default: v = 32'(bus_a.out_ovf);
            endcase
        else
            case (sel)
                0: v = 32'(bus_b.in_ready);
                1: v = 32'(bus_b.out_valid);
                2: v = 32'(bus_b.out_sum);
                3: v = 32'(bus_b.out_count);
                default: v = 32'(bus_b.out_ovf);
            endcase
        return v;
    endfunction

    task automatic check_outputs(input string phase);
        for (int k = 0; k < 2; k++) begin
            string sfx = (k == 0) ? "_a" : "_b";
            check({phase, "_in_ready", sfx},  obs_of(k, 0), 32'(!m_hold[k]));
            check({phase, "_out_valid", sfx}, obs_of(k, 1), 32'(m_hold[k]));
            check({phase, "_out_sum", sfx},   obs_of(k, 2), 32'(m_sum[k]));
            check({phase, "_out_count", sfx}, obs_of(k, 3), 32'(m_count[k]));
            check({phase, "_out_ovf", sfx},   obs_of(k, 4), 32'(m_ovf[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k]  = 1'b0;
            m_total[k] = 0;
            m_cnt[k]   = 0;
            m_sum[k]   = 0;
            m_count[k] = 0;
            m_ovf[k]   = 1'b0;
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input string phase, input bit v, input int d, input bit f, input bit r);
        in_valid  = v;
        in_data   = DW'(d);
        in_flush  = f;
        out_ready = r;
        #1;
        check_outputs(phase);
        if (bus_a.in_ready === 1'b0) ready_low_a++;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!m_hold[k]) begin
                if (v) begin
                    m_total[k] += d;
                    m_cnt[k]++;
                end
                if ((v && m_cnt[k] == N) || (f && m_cnt[k] > 0)) begin
                    m_sum[k]   = frame_sum(m_total[k], aw[k]);
                    m_count[k] = m_cnt[k];
                    m_ovf[k]   = m_total[k] > ((1 << aw[k]) - 1);
                    m_hold[k]  = 1'b1;
                    m_total[k] = 0;
                    m_cnt[k]   = 0;
                end
            end else if (r) begin
                m_hold[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input string phase, input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(phase);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs(phase);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset("por", 2);

        // Basic frame with the consumer always ready.
        ready_low_a = 0;
        cycle("basic", 1, 10, 0, 1);
        cycle("basic", 1, 20, 0, 1);
        cycle("basic", 1, 30, 0, 1);
        cycle("basic", 1, 40, 0, 1);
        check("basic_valid", 32'(bus_a.out_valid), 32'd1);
        check("basic_sum", 32'(bus_a.out_sum), 32'd100);
        check("basic_count", 32'(bus_a.out_count), 32'd4);
        check("basic_ovf", 32'(bus_a.out_ovf), 32'd0);
        cycle("basic", 0, 0, 0, 1);
        cycle("basic", 0, 0, 0, 1);
        cycle("basic", 0, 0, 0, 1);
        check("basic_ready_low_cycles", 32'(ready_low_a), 32'd1);

        // Backpressure: result held while a stalled producer offers 99.
        cycle("bp", 1, 10, 0, 0);
        cycle("bp", 1, 20, 0, 0);
        cycle("bp", 1, 30, 0, 0);
        cycle("bp", 1, 40, 0, 0);
        for (int i = 0; i < 5; i++) cycle("bp_hold", 1, 99, 0, 0);
        check("bp_sum_held", 32'(bus_a.out_sum), 32'd100);
        check("bp_ready_low", 32'(bus_a.in_ready), 32'd0);
        cycle("bp_release", 1, 99, 0, 1);
        cycle("bp_after", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle("bp_next", 1, 1, 0, 1);
        check("bp_next_sum", 32'(bus_a.out_sum), 32'd4);
        cycle("bp_next", 0, 0, 0, 1);

        // Early flush on the second accept, then a flush with nothing pending.
        cycle("flush", 1, 255, 0, 1);
        cycle("flush", 1, 255, 1, 1);
        check("flush_sum", 32'(bus_a.out_sum), 32'd510);
        check("flush_count", 32'(bus_a.out_count), 32'd2);
        cycle("flush", 0, 0, 0, 1);
        cycle("flush_idle", 0, 0, 1, 1);
        check("flush_idle_no_valid", 32'(bus_a.out_valid), 32'd0);
        cycle("flush_idle", 0, 0, 0, 1);

        // Overflow on the AW=9 instance.
        for (int i = 0; i < 4; i++) cycle("ovf", 1, 255, 0, 1);
`ifdef SUM_ACC_SAT_EN
        check("ovf_sum_b", 32'(bus_b.out_sum), 32'd511);
`else
        check("ovf_sum_b", 32'(bus_b.out_sum), 32'd508);
`endif
        check("ovf_flag_b", 32'(bus_b.out_ovf), 32'd1);
        check("ovf_sum_a", 32'(bus_a.out_sum), 32'd1020);
        cycle("ovf", 0, 0, 0, 1);

        // Reset in the middle of a frame discards the partial total.
        cycle("rst", 1, 5, 0, 1);
        cycle("rst", 1, 6, 0, 1);
        apply_reset("rst_mid", 2);
        for (int i = 1; i <= 4; i++) cycle("rst_next", 1, i, 0, 1);
        check("rst_next_sum", 32'(bus_a.out_sum), 32'd10);
        check("rst_next_count", 32'(bus_a.out_count), 32'd4);
        cycle("rst_next", 0, 0, 0, 1);

        // Bubbles between samples.
        for (int i = 1; i <= 4; i++) begin
            cycle("bubble", 1, i, 0, 1);
            if (i < 4)
                for (int j = 0; j < 3; j++) cycle("bubble_idle", 0, 0, 0, 1);
        end
        check("bubble_valid", 32'(bus_a.out_valid), 32'd1);
        check("bubble_sum", 32'(bus_a.out_sum), 32'd10);
        check("bubble_count", 32'(bus_a.out_count), 32'd4);
        cycle("bubble", 0, 0, 0, 1);

        // Randomized traffic: valid, data, flush and consumer ready all vary.
        for (int i = 0; i < 400; i++) begin
            bit v = ($urandom_range(0, 9) < 7);
            bit f = ($urandom_range(0, 9) == 0);
            bit r = ($urandom_range(0, 9) < 6);
            cycle("rand", v, int'($urandom_range(0, 255)), f, r);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
